// File: rtl/count_capture.sv
// count_capture: queues every change of an upstream count value until EndVal is seen.
// Build option: define COUNT_CAPTURE_STEP_CHECK_EN to flag RUN-state captures that are not last+1 on Error_o.
module count_capture #(
    parameter int Width  = 32,
    parameter int Depth  = 4,
    parameter int EndVal = 64
) (
    input  logic             Clk_i,
    input  logic             Reset_i,
    input  logic [Width-1:0] Data_i,
    output logic             Valid_o,
    input  logic             Ready_i,
    output logic [Width-1:0] Data_o,
    output logic             Done_o,
    output logic             Overflow_o,
    output logic             Error_o
);

    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;
    localparam logic [Width-1:0] END_VAL  = Width'(EndVal);
    localparam logic [CW-1:0]    FULL_CNT = CW'(Depth);

    typedef enum logic [1:0] {
        ST_FIRST,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [Width-1:0] r_mem [Depth];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [Width-1:0] r_last;
    logic             r_overflow;

    logic             w_capture;
    logic             w_is_end;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    assign w_is_end = (Data_i == END_VAL);
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == FULL_CNT);

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            ST_FIRST: begin
                w_capture    = 1'b1;
                w_state_next = w_is_end ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (Data_i != r_last) begin
                    w_capture = 1'b1;
                    if (w_is_end) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            default: begin
                w_capture    = 1'b0;
                w_state_next = ST_DONE;
            end
        endcase
        if (Reset_i) begin
            w_capture = 1'b0;
        end
    end

    // A full FIFO still accepts a capture when the head leaves in the same cycle.
    assign w_pop  = !w_empty && Ready_i;
    assign w_push = w_capture && (!w_full || w_pop);
    assign w_drop = w_capture && w_full && !w_pop;

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            r_state    <= ST_FIRST;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_last     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_capture) begin
                r_last <= Data_i;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= Data_i;
        end
    end

    assign Valid_o    = !w_empty;
    assign Data_o     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign Done_o     = (r_state == ST_DONE);
    assign Overflow_o = r_overflow;

`ifdef COUNT_CAPTURE_STEP_CHECK_EN
    logic             r_error;
    logic [Width-1:0] w_last_inc;

    assign w_last_inc = r_last + Width'(1);

    // The very first sample after reset has no predecessor, so only RUN captures are checked.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            r_error <= 1'b0;
        end else if (w_capture && (r_state == ST_RUN) && (Data_i != w_last_inc)) begin
            r_error <= 1'b1;
        end
    end

    assign Error_o = r_error;
`else
    assign Error_o = 1'b0;
`endif

endmodule

// File: tb/tb_count_capture.sv
// Randomised scoreboard bench for count_capture: queue-based reference model, monitor checks every cycle.
module tb_count_capture;

    localparam int W = 32;
    localparam int D = 4;
    localparam int E = 64;

    logic         Clk_i = 1'b0;
    logic         Reset_i;
    logic [W-1:0] Data_i;
    logic         Valid_o;
    logic         Ready_i;
    logic [W-1:0] Data_o;
    logic         Done_o;
    logic         Overflow_o;
    logic         Error_o;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [W-1:0] m_fifo [$];
    logic [W-1:0] exp_q  [$];
    int           m_phase;       // 0: no sample yet, 1: running, 2: end value seen
    logic [W-1:0] m_last;
    bit           m_ovf;
    bit           m_err;
    bit           m_init = 1'b0;
    bit           m_after_reset = 1'b0;

    count_capture #(
        .Width  (W),
        .Depth  (D),
        .EndVal (E)
    ) dut (
        .Clk_i      (Clk_i),
        .Reset_i    (Reset_i),
        .Data_i     (Data_i),
        .Valid_o    (Valid_o),
        .Ready_i    (Ready_i),
        .Data_o     (Data_o),
        .Done_o     (Done_o),
        .Overflow_o (Overflow_o),
        .Error_o    (Error_o)
    );

    initial forever #5 Clk_i = ~Clk_i;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, req, $time);
        end
    endtask

    // Model: advances on each rising edge from the inputs the DUT sees.
    initial forever begin
        bit full;
        bit pop;
        bit cap;
        @(posedge Clk_i);
        if (Reset_i) begin
            m_fifo.delete();
            exp_q.delete();
            m_phase       = 0;
            m_last        = '0;
            m_ovf         = 1'b0;
            m_err         = 1'b0;
            m_init        = 1'b1;
            m_after_reset = 1'b1;
        end else if (m_init) begin
            m_after_reset = 1'b0;
            full = (m_fifo.size() == D);
            pop  = (m_fifo.size() != 0) && Ready_i;
            cap  = (m_phase == 0) || ((m_phase == 1) && (Data_i != m_last));
            if (pop) void'(m_fifo.pop_front());
            if (cap) begin
                if (!full || pop) begin
                    m_fifo.push_back(Data_i);
                    exp_q.push_back(Data_i);
                end else begin
                    m_ovf = 1'b1;
                end
`ifdef COUNT_CAPTURE_STEP_CHECK_EN
                if ((m_phase == 1) && (Data_i != W'(m_last + 1))) m_err = 1'b1;
`endif
                m_last  = Data_i;
                m_phase = (Data_i == W'(E)) ? 2 : 1;
            end
        end
    end

    // Monitor: samples after the falling edge, consumes the scoreboard on each handshake.
    initial forever begin
        @(negedge Clk_i);
        #1;
        if (m_init) begin
            chk("valid", W'(Valid_o), W'(m_fifo.size() != 0));
            chk("done", W'(Done_o), W'(m_phase == 2));
            chk("overflow", W'(Overflow_o), W'(m_ovf));
            chk("error", W'(Error_o), W'(m_err));
            if (Valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL data: got %0d with Valid_o=1, expected no entry at t=%0t", Data_o, $time);
                end else begin
                    chk("data", Data_o, exp_q[0]);
                    if (Ready_i) begin
                        $display("pop %0d at t=%0t", Data_o, $time);
                        void'(exp_q.pop_front());
                    end
                end
            end else if (m_after_reset) begin
                chk("reset_data", Data_o, '0);
            end
        end
    end

    task automatic step(input logic rst, input logic [W-1:0] d, input logic rdy);
        Reset_i = rst;
        Data_i  = d;
        Ready_i = rdy;
        @(negedge Clk_i);
    endtask

    task automatic do_reset();
        step(1'b1, '0, 1'b0);
        step(1'b1, '0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] d;
        int           r;
        logic         rst;
        Reset_i = 1'b1;
        Data_i  = '0;
        Ready_i = 1'b0;
        repeat (2) @(negedge Clk_i);

        // Simple in-order stream
        do_reset();
        for (int v = 8; v <= 10; v++) step(1'b0, W'(v), 1'b1);
        repeat (3) step(1'b0, W'(10), 1'b1);

        // Repeated value queued once
        repeat (5) step(1'b0, W'(12), 1'b0);
        repeat (3) step(1'b0, W'(12), 1'b1);

        // Overflow when full, then drain
        do_reset();
        for (int v = 8; v <= 13; v++) step(1'b0, W'(v), 1'b0);
        repeat (6) step(1'b0, W'(13), 1'b1);

        // Push and pop together while full
        do_reset();
        for (int v = 20; v <= 23; v++) step(1'b0, W'(v), 1'b0);
        step(1'b0, W'(24), 1'b1);
        step(1'b0, W'(25), 1'b0);
        repeat (6) step(1'b0, W'(25), 1'b1);

        // End value terminates capture
        do_reset();
        for (int v = 62; v <= 65; v++) step(1'b0, W'(v), 1'b1);
        step(1'b0, W'(3), 1'b1);
        repeat (3) step(1'b0, W'(65), 1'b1);

        // End value captured first, and dropped while full
        do_reset();
        step(1'b0, W'(E), 1'b0);
        step(1'b0, W'(7), 1'b1);
        do_reset();
        for (int v = 40; v <= 43; v++) step(1'b0, W'(v), 1'b0);
        step(1'b0, W'(E), 1'b0);
        step(1'b0, W'(70), 1'b0);
        repeat (6) step(1'b0, W'(70), 1'b1);

        // Step violation, then reset with entries still queued
        do_reset();
        step(1'b0, W'(8), 1'b0);
        step(1'b0, W'(9), 1'b0);
        step(1'b0, W'(11), 1'b0);
        step(1'b0, W'(11), 1'b0);
        step(1'b1, W'(11), 1'b1);
        step(1'b0, W'(30), 1'b1);
        step(1'b0, W'(31), 1'b1);
        repeat (3) step(1'b0, W'(31), 1'b1);

        // Randomised traffic around the end value
        d = W'(50);
        for (int i = 0; i < 1200; i++) begin
            r = $urandom_range(0, 9);
            if (r >= 4 && r <= 7) d = d + W'(1);
            else if (r == 8) d = W'($urandom_range(0, 70));
            else if (r == 9) d = W'($urandom_range(56, 66));
            rst = ($urandom_range(0, 39) == 0);
            step(rst, d, ($urandom_range(0, 9) < 7));
        end

        // Final drain: holding the value causes at most one more capture
        repeat (8) step(1'b0, d, 1'b1);
        #2;
        chk("drained", W'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
